mem_read_arbiter: RTL and testbench



---
 rtl/mem_read_arbiter.sv | 110 +++++++++++
 tb/tb_mem_read_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: round-robin sharing of one line-wide memory read port
// between NrPorts cache requesters. One outstanding read at a time; the
// response is dropped if the owner withdrew or moved to another line.
module mem_read_arbiter #(
  parameter int unsigned NrPorts        = 2,
  parameter int unsigned ByteOffsetBits = 4,
  parameter int unsigned LineSize       = 128,
  localparam int unsigned OwnerW        = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [NrPorts-1:0]       req_read_en_i,
  input  logic [NrPorts-1:0][31:0] req_addr_i,
  output logic [NrPorts-1:0]       req_read_valid_o,
  output logic [LineSize-1:0]      req_read_data_o,
  output logic [31:0]              mem_addr_o,
  output logic                     mem_read_en_o,
  input  logic                     mem_read_valid_i,
  input  logic [LineSize-1:0]      mem_read_data_i,
  output logic                     busy_o,
  output logic [OwnerW-1:0]        owner_o
);

  localparam int unsigned LineW = 32 - ByteOffsetBits;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]        state_q;
  logic [OwnerW-1:0] rr_ptr_q;
  logic [OwnerW-1:0] owner_q;
  logic [LineW-1:0]  line_q;
  logic              abort_q;

  logic              any_req;
  logic [OwnerW-1:0] winner;
  logic [OwnerW-1:0] idx;
  logic              owner_match;
  logic [OwnerW-1:0] rr_next;

  // Round-robin search: first requesting port at or above rr_ptr, wrapping.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = '0;
    for (int unsigned i = 0; i < NrPorts; i++) begin
      idx = OwnerW'((32'(rr_ptr_q) + i) % NrPorts);
      if (!any_req && req_read_en_i[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  // Owner still wants the latched line this cycle.
  always_comb begin
    owner_match = req_read_en_i[owner_q] &&
                  (req_addr_i[owner_q][31:ByteOffsetBits] == line_q);
    rr_next     = (owner_q == OwnerW'(NrPorts - 1)) ? '0 : owner_q + 1'b1;
  end

  // FSM, pointer, owner/line latch and sticky abort flag.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      line_q   <= '0;
      abort_q  <= 1'b0;
    end else if (state_q == StIdle) begin
      // A strobe seen in IDLE is stale and deliberately ignored here.
      if (any_req) begin
        state_q <= StBusy;
        owner_q <= winner;
        line_q  <= req_addr_i[winner][31:ByteOffsetBits];
        abort_q <= 1'b0;
      end
    end else begin
      if (mem_read_valid_i) begin
        state_q  <= StIdle;
        rr_ptr_q <= rr_next;
      end else if (!owner_match) begin
        abort_q <= 1'b1;
      end
    end
  end

  // Memory request, completion pulse and response routing.
  always_comb begin
    mem_read_en_o    = 1'b0;
    mem_addr_o       = '0;
    req_read_valid_o = '0;
    req_read_data_o  = '0;
    if (state_q == StBusy) begin
      mem_read_en_o = 1'b1;
      mem_addr_o    = {line_q, {ByteOffsetBits{1'b0}}};
      if (mem_read_valid_i && !abort_q && owner_match) begin
        req_read_valid_o[owner_q] = 1'b1;
        req_read_data_o           = mem_read_data_i;
      end
    end else if (any_req) begin
      mem_read_en_o = 1'b1;
      mem_addr_o    = {req_addr_i[winner][31:ByteOffsetBits], {ByteOffsetBits{1'b0}}};
    end
  end

  assign busy_o  = (state_q == StBusy);
  assign owner_o = owner_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter: directed bench with a completion scoreboard.
module tb_mem_read_arbiter;

  localparam int unsigned NP = 2;
  localparam int unsigned LS = 128;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NP-1:0]     req_en = '0;
  logic [NP-1:0][31:0] req_addr = '0;
  logic [NP-1:0]     valid;
  logic [LS-1:0]     rdata;
  logic [31:0]       mem_addr;
  logic              mem_en;
  logic              mem_valid = 1'b0;
  logic [LS-1:0]     mem_data = '0;
  logic              busy;
  logic [0:0]        owner;

  typedef struct {
    int unsigned   port;
    logic [LS-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [NP-1:0] mon_ev;
  int tests = 0;
  int fails = 0;

  mem_read_arbiter #(.NrPorts(NP), .ByteOffsetBits(4), .LineSize(LS)) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .req_read_en_i    (req_en),
    .req_addr_i       (req_addr),
    .req_read_valid_o (valid),
    .req_read_data_o  (rdata),
    .mem_addr_o       (mem_addr),
    .mem_read_en_o    (mem_en),
    .mem_read_valid_i (mem_valid),
    .mem_read_data_i  (mem_data),
    .busy_o           (busy),
    .owner_o          (owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LS-1:0] obs, input logic [LS-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int unsigned p, input logic [LS-1:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (valid !== '0) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_pulse: observed valid=%b data=%0h expected no pulse", valid, rdata);
      end else begin
        mon_e  = sb.pop_front();
        mon_ev = NP'(1) << mon_e.port;
        chk("pulse_port", LS'(valid), LS'(mon_ev));
        chk("pulse_data", rdata, mon_e.data);
      end
    end else begin
      chk("idle_data_zero", rdata, '0);
    end
  end

  initial begin
    logic [LS-1:0] d;

    // Reset state
    adv(); adv();
    sample();
    chk("rst_busy", LS'(busy), 0);
    chk("rst_mem_en", LS'(mem_en), 0);
    chk("rst_addr", LS'(mem_addr), 0);
    chk("rst_owner", LS'(owner), 0);
    adv();
    rstn = 1'b1;

    // Single request, 3-cycle memory latency
    req_addr[0] = 32'h0000_1234;
    req_en = 2'b01;
    sample();
    chk("t1_c0_en", LS'(mem_en), 1);
    chk("t1_c0_addr", LS'(mem_addr), 32'h0000_1230);
    chk("t1_c0_busy", LS'(busy), 0);
    adv(); sample();
    chk("t1_c1_busy", LS'(busy), 1);
    chk("t1_c1_addr", LS'(mem_addr), 32'h0000_1230);
    adv(); sample();
    chk("t1_c2_busy", LS'(busy), 1);
    chk("t1_c2_en", LS'(mem_en), 1);
    adv();
    d = 128'hDDDD_CCCC_BBBB_AAAA_1111_2222_3333_4444;
    mem_valid = 1'b1; mem_data = d; push(0, d);
    sample();
    chk("t1_c3_busy", LS'(busy), 1);
    chk("t1_drained", LS'(sb.size()), 0);
    adv();
    mem_valid = 1'b0; mem_data = '0; req_en = '0;
    sample();
    chk("t1_idle_busy", LS'(busy), 0);
    chk("t1_idle_en", LS'(mem_en), 0);
    chk("t1_idle_addr", LS'(mem_addr), 0);

    // Simultaneous requests straight after reset
    adv(); rstn = 1'b0;
    adv(); rstn = 1'b1;
    req_addr[0] = 32'h100; req_addr[1] = 32'h200; req_en = 2'b11;
    sample();
    chk("t2_first_addr", LS'(mem_addr), 32'h100);
    adv(); sample();
    chk("t2_first_owner", LS'(owner), 0);
    adv();
    d = 128'hA0A0; mem_valid = 1'b1; mem_data = d; push(0, d);
    sample();
    chk("t2_first_drained", LS'(sb.size()), 0);
    adv();
    mem_valid = 1'b0; req_en = 2'b10;
    sample();
    chk("t2_b2b_busy", LS'(busy), 0);
    chk("t2_b2b_en", LS'(mem_en), 1);
    chk("t2_b2b_addr", LS'(mem_addr), 32'h200);
    adv(); sample();
    chk("t2_second_owner", LS'(owner), 1);
    adv();
    d = 128'hB0B0; mem_valid = 1'b1; mem_data = d; push(1, d);
    sample();
    chk("t2_second_drained", LS'(sb.size()), 0);
    adv();
    mem_valid = 1'b0; req_en = '0;
    sample();
    chk("t2_end_en", LS'(mem_en), 0);
    chk("t2_end_owner", LS'(owner), 1);

    // Fairness with both ports requesting continuously; strobe in first BUSY cycle
    req_en = 2'b11;
    for (int k = 0; k < 6; k++) begin
      sample();
      chk("t3_issue_en", LS'(mem_en), 1);
      chk("t3_issue_addr", LS'(mem_addr), (k % 2 == 0) ? 32'h100 : 32'h200);
      adv();
      d = LS'(128'hF000 + k);
      mem_valid = 1'b1; mem_data = d; push(k % 2, d);
      sample();
      chk("t3_owner", LS'(owner), LS'(k % 2));
      chk("t3_drained", LS'(sb.size()), 0);
      adv();
      mem_valid = 1'b0;
    end
    req_en = '0;
    sample();
    chk("t3_end_en", LS'(mem_en), 0);

    // Withdrawal: port1 drops its request one cycle into BUSY
    req_addr[1] = 32'h300; req_en = 2'b10;
    sample();
    chk("t4_issue_addr", LS'(mem_addr), 32'h300);
    adv(); sample();
    chk("t4_busy", LS'(busy), 1);
    chk("t4_owner", LS'(owner), 1);
    adv();
    req_en = '0;
    sample();
    chk("t4_hold_en", LS'(mem_en), 1);
    chk("t4_hold_addr", LS'(mem_addr), 32'h300);
    adv(); sample();
    chk("t4_hold2_en", LS'(mem_en), 1);
    adv();
    mem_valid = 1'b1; mem_data = 128'h5555;
    sample();
    chk("t4_no_pulse", LS'(valid), 0);
    chk("t4_data_zero", rdata, 0);
    chk("t4_strobe_en", LS'(mem_en), 1);
    adv();
    mem_valid = 1'b0;
    sample();
    chk("t4_idle_busy", LS'(busy), 0);
    chk("t4_idle_en", LS'(mem_en), 0);

    // Address change mid-BUSY and back again
    req_addr[1] = 32'h300; req_en = 2'b10;
    sample();
    chk("t5_issue_addr", LS'(mem_addr), 32'h300);
    adv(); sample();
    chk("t5_busy", LS'(busy), 1);
    adv();
    req_addr[1] = 32'h340;
    sample();
    chk("t5_latched_addr", LS'(mem_addr), 32'h300);
    adv();
    req_addr[1] = 32'h300;
    adv();
    mem_valid = 1'b1; mem_data = 128'h6666;
    sample();
    chk("t5_no_pulse", LS'(valid), 0);
    chk("t5_data_zero", rdata, 0);
    adv();
    mem_valid = 1'b0;
    sample();
    chk("t5_reissue_busy", LS'(busy), 0);
    chk("t5_reissue_en", LS'(mem_en), 1);
    chk("t5_reissue_addr", LS'(mem_addr), 32'h300);
    adv();
    d = 128'hE0E0; mem_valid = 1'b1; mem_data = d; push(1, d);
    sample();
    chk("t5_drained", LS'(sb.size()), 0);
    adv();
    mem_valid = 1'b0; req_en = '0;

    // Strobe in IDLE while a request is being issued is ignored
    req_addr[0] = 32'h407; req_en = 2'b01;
    mem_valid = 1'b1; mem_data = 128'h7777;
    sample();
    chk("t6_idle_strobe_valid", LS'(valid), 0);
    chk("t6_issue_addr", LS'(mem_addr), 32'h400);
    adv();
    mem_valid = 1'b0;
    sample();
    chk("t6_busy", LS'(busy), 1);
    adv();
    d = 128'h1234_5678; mem_valid = 1'b1; mem_data = d; push(0, d);
    sample();
    chk("t6_drained", LS'(sb.size()), 0);
    adv();
    mem_valid = 1'b0; req_en = '0;

    // Reset mid-BUSY; stale strobe two cycles after release
    req_addr[1] = 32'h500; req_en = 2'b10;
    sample();
    chk("t7_issue_addr", LS'(mem_addr), 32'h500);
    adv(); sample();
    chk("t7_busy", LS'(busy), 1);
    chk("t7_owner", LS'(owner), 1);
    adv();
    rstn = 1'b0; req_en = '0;
    sample();
    chk("t7_rst_busy", LS'(busy), 0);
    chk("t7_rst_en", LS'(mem_en), 0);
    chk("t7_rst_addr", LS'(mem_addr), 0);
    chk("t7_rst_owner", LS'(owner), 0);
    adv(); adv();
    rstn = 1'b1;
    adv(); adv();
    mem_valid = 1'b1; mem_data = 128'h8888;
    sample();
    chk("t7_stale_valid", LS'(valid), 0);
    chk("t7_stale_busy", LS'(busy), 0);
    adv();
    mem_valid = 1'b0;

    // Pointer is back at 0 after reset: port0 wins a tie
    req_addr[0] = 32'h600; req_addr[1] = 32'h700; req_en = 2'b11;
    sample();
    chk("t7_tie_addr", LS'(mem_addr), 32'h600);
    adv();
    req_en = '0;
    mem_valid = 1'b1; mem_data = 128'h9999;
    sample();
    chk("t7_abort_valid", LS'(valid), 0);
    adv();
    mem_valid = 1'b0;
    sample();
    chk("sb_empty", LS'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
